// File: rtl/matrix_cmd_sequencer.sv
// matrix_cmd_sequencer
// Decodes a header/payload command stream and sequences configuration and
// execution requests to a matrix array. It tracks whether the array has a
// valid configuration, times out a stalled array and keeps a sticky error
// code until software clears it.

`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

package matrix_seq_pkg;

   // Operations understood by the matrix array. Every 3-bit encoding is
   // named, so any low-order bits of an EXEC header cast to a legal value.
   typedef enum logic [2:0] {
      OP_MATMUL    = 3'd0,
      OP_ADD       = 3'd1,
      OP_SUB       = 3'd2,
      OP_HADAMARD  = 3'd3,
      OP_TRANSPOSE = 3'd4,
      OP_SCALE     = 3'd5,
      OP_RELU      = 3'd6,
      OP_CLEAR     = 3'd7
   } matrix_op_t;

endpackage

module matrix_cmd_sequencer
   import matrix_seq_pkg::*;
#(
   parameter logic [15:0] MAX_DIM        = 16'd64,
   // Must be at least 2: the array is waited on for TIMEOUT_CYCLES-1 cycles
   // after the start pulse before the sequencer gives up.
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [`INSTRUCTION_WIDTH-1:0] cmd_data,
   output matrix_op_t                    operation,
   output logic                          start_operation,
   input  logic                          operation_done,
   input  logic                          operation_error,
   output logic                          config_valid,
   output logic [`INSTRUCTION_WIDTH-1:0] config_data,
   output logic                          seq_error,
   output logic [2:0]                    err_code,
   input  logic                          err_clear,
   output logic [15:0]                   ops_completed
);

   localparam logic [3:0] OPC_NOP    = 4'h0;
   localparam logic [3:0] OPC_CONFIG = 4'h1;
   localparam logic [3:0] OPC_EXEC   = 4'h2;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_OPCODE   = 3'd1;
   localparam logic [2:0] ERR_DIMS     = 3'd2;
   localparam logic [2:0] ERR_UNCONFIG = 3'd3;
   localparam logic [2:0] ERR_ARRAY    = 3'd4;
   localparam logic [2:0] ERR_TIMEOUT  = 3'd5;

   // The wait counter only has to hold values up to TIMEOUT_CYCLES-1.
   localparam int                 CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_PAYLOAD,
      S_ISSUE_CONFIG,
      S_CFG_SETTLE,
      S_ISSUE_START,
      S_WAIT_DONE,
      S_ERROR
   } state_t;

   state_t           state;
   logic             configured;
   logic             settle_cnt;
   logic [CNT_W-1:0] wait_cnt;

   logic             accept;
   logic [3:0]       opcode;
   logic [15:0]      rows;
   logic [15:0]      cols;
   logic             dims_bad;
   logic             wait_expired;
   matrix_op_t       exec_op;

   assign accept       = cmd_valid && cmd_ready;
   assign opcode       = cmd_data[31:28];
   assign rows         = cmd_data[31:16];
   assign cols         = cmd_data[15:0];
   assign dims_bad     = (rows == 16'd0) || (rows > MAX_DIM) ||
                         (cols == 16'd0) || (cols > MAX_DIM);
   assign wait_expired = ((wait_cnt + CNT_ONE) == WAIT_LAST);
   assign exec_op      = matrix_op_t'(cmd_data[$bits(matrix_op_t)-1:0]);

   // Command FSM; every output is registered and updated alongside the state
   // it belongs to, so pulses line up exactly with their state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         cmd_ready       <= 1'b0;
         start_operation <= 1'b0;
         config_valid    <= 1'b0;
         config_data     <= '0;
         operation       <= matrix_op_t'(0);
         seq_error       <= 1'b0;
         err_code        <= ERR_NONE;
         ops_completed   <= 16'd0;
         configured      <= 1'b0;
         settle_cnt      <= 1'b0;
         wait_cnt        <= '0;
      end else begin
         start_operation <= 1'b0;
         config_valid    <= 1'b0;

         case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               if (accept) begin
                  case (opcode)
                     OPC_NOP: begin
                        state <= S_IDLE;
                     end
                     OPC_CONFIG: begin
                        state <= S_GET_PAYLOAD;
                     end
                     OPC_EXEC: begin
                        if (configured) begin
                           operation       <= exec_op;
                           start_operation <= 1'b1;
                           wait_cnt        <= '0;
                           cmd_ready       <= 1'b0;
                           state           <= S_ISSUE_START;
                        end else begin
                           seq_error <= 1'b1;
                           err_code  <= ERR_UNCONFIG;
                           cmd_ready <= 1'b0;
                           state     <= S_ERROR;
                        end
                     end
                     default: begin
                        seq_error <= 1'b1;
                        err_code  <= ERR_OPCODE;
                        cmd_ready <= 1'b0;
                        state     <= S_ERROR;
                     end
                  endcase
               end
            end

            S_GET_PAYLOAD: begin
               if (accept) begin
                  cmd_ready <= 1'b0;
                  if (dims_bad) begin
                     seq_error <= 1'b1;
                     err_code  <= ERR_DIMS;
                     state     <= S_ERROR;
                  end else begin
                     config_data  <= cmd_data;
                     config_valid <= 1'b1;
                     state        <= S_ISSUE_CONFIG;
                  end
               end
            end

            S_ISSUE_CONFIG: begin
               configured <= 1'b1;
               settle_cnt <= 1'b0;
               state      <= S_CFG_SETTLE;
            end

            S_CFG_SETTLE: begin
               if (settle_cnt) begin
                  cmd_ready <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  settle_cnt <= 1'b1;
               end
            end

            S_ISSUE_START: begin
               wait_cnt <= '0;
               state    <= S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
               if (operation_error) begin
                  seq_error <= 1'b1;
                  err_code  <= ERR_ARRAY;
                  state     <= S_ERROR;
               end else if (operation_done) begin
                  ops_completed <= ops_completed + 16'd1;
                  cmd_ready     <= 1'b1;
                  state         <= S_IDLE;
               end else if (wait_expired) begin
                  seq_error <= 1'b1;
                  err_code  <= ERR_TIMEOUT;
                  state     <= S_ERROR;
               end else begin
                  wait_cnt <= wait_cnt + CNT_ONE;
               end
            end

            S_ERROR: begin
               cmd_ready <= 1'b0;
               if (err_clear) begin
                  seq_error <= 1'b0;
                  err_code  <= ERR_NONE;
                  cmd_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end

            default: begin
               cmd_ready <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
